// File: rtl/dm_arbiter_if.sv
// Two-requester data-memory access bus: request/grant/completion per port plus the memory side.
interface dm_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, MemReadData,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
        output MemAddr, MemWriteData, MemWrite, MemRead
    );

    // Requester and memory view
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, MemReadData,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
        input  MemAddr, MemWriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data memory between the MEM stage (port 0)
// and the loader/debug port (port 1). Each access is ACCESS + DONE, back-to-back capable.
module dm_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic           clk,
    input  logic           rst,
    dm_arbiter_if.slave    bus
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arbState_t;

    arbState_t   state;
    logic        lastGnt;
    logic        curPort;
    logic        curWe;
    logic        curIllegal;

    logic        anyReq;
    logic        winner;
    logic        winWe;
    logic [31:0] winAddr;
    logic [31:0] winData;
    logic        winIllegal;

    // Pick the winning port and qualify its access
    always_comb begin
        anyReq     = bus.req0 | bus.req1;
        winner     = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~lastGnt;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
        winWe      = winner ? bus.we1    : bus.we0;
        winAddr    = winner ? bus.addr1  : bus.addr0;
        winData    = winner ? bus.wdata1 : bus.wdata0;
        winIllegal = (winAddr[1:0] != 2'b00) || (winAddr > MAX_ADDR);
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            lastGnt          <= 1'b1;
            curPort          <= 1'b0;
            curWe            <= 1'b0;
            curIllegal       <= 1'b0;
            bus.gnt0         <= 1'b0;
            bus.gnt1         <= 1'b0;
            bus.done0        <= 1'b0;
            bus.done1        <= 1'b0;
            bus.err0         <= 1'b0;
            bus.err1         <= 1'b0;
            bus.rdata0       <= 32'd0;
            bus.rdata1       <= 32'd0;
            bus.MemAddr      <= 32'd0;
            bus.MemWriteData <= 32'd0;
            bus.MemWrite     <= 1'b0;
            bus.MemRead      <= 1'b0;
        end else begin
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.done1    <= 1'b0;
            bus.err0     <= 1'b0;
            bus.err1     <= 1'b0;
            bus.rdata0   <= 32'd0;
            bus.rdata1   <= 32'd0;
            bus.MemWrite <= 1'b0;
            bus.MemRead  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (anyReq) begin
                        state            <= ACCESS;
                        lastGnt          <= winner;
                        curPort          <= winner;
                        curWe            <= winWe;
                        curIllegal       <= winIllegal;
                        bus.MemAddr      <= winAddr;
                        bus.MemWriteData <= winData;
                        bus.gnt0         <= ~winner;
                        bus.gnt1         <= winner;
                        bus.MemWrite     <= ~winIllegal & winWe;
                        bus.MemRead      <= ~winIllegal & ~winWe;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (curPort) begin
                        bus.done1  <= 1'b1;
                        bus.err1   <= curIllegal;
                        bus.rdata1 <= (!curIllegal && !curWe) ? bus.MemReadData : 32'd0;
                    end else begin
                        bus.done0  <= 1'b1;
                        bus.err0   <= curIllegal;
                        bus.rdata0 <= (!curIllegal && !curWe) ? bus.MemReadData : 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a big-endian byte memory acting on negedge.
module tb_dm_arbiter;

    logic clk;
    logic rst;
    int   errCount;
    int   checkCount;
    logic [7:0] mem [0:127];

    dm_arbiter_if bus ();

    dm_arbiter #(.MEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model
    always @(negedge clk) begin
        if (bus.MemWrite && bus.MemAddr <= 32'd124) begin
            mem[bus.MemAddr[6:0]]        <= bus.MemWriteData[31:24];
            mem[bus.MemAddr[6:0] + 7'd1] <= bus.MemWriteData[23:16];
            mem[bus.MemAddr[6:0] + 7'd2] <= bus.MemWriteData[15:8];
            mem[bus.MemAddr[6:0] + 7'd3] <= bus.MemWriteData[7:0];
        end
        if (bus.MemRead && bus.MemAddr <= 32'd124) begin
            bus.MemReadData <= {mem[bus.MemAddr[6:0]], mem[bus.MemAddr[6:0] + 7'd1],
                                mem[bus.MemAddr[6:0] + 7'd2], mem[bus.MemAddr[6:0] + 7'd3]};
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memWord(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    function automatic logic [31:0] p0Outs();
        return {28'd0, bus.gnt0, bus.done0, bus.err0, |bus.rdata0};
    endfunction

    function automatic logic [31:0] p1Outs();
        return {28'd0, bus.gnt1, bus.done1, bus.err1, |bus.rdata1};
    endfunction

    // One port-0 read with hand-computed outcome
    task automatic readP0(input logic [31:0] a, input logic expErr, input logic [31:0] expData);
        string t;
        t = $sformatf("rd0_%02h", a);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a;
        tick();
        checkVal({t, "_gnt"}, 32'(bus.gnt0), 32'd1);
        checkVal({t, "_strobe"}, {30'd0, bus.MemRead, bus.MemWrite}, expErr ? 32'd0 : 32'd2);
        bus.req0 = 1'b0;
        tick();
        checkVal({t, "_done"}, 32'(bus.done0), 32'd1);
        checkVal({t, "_err"}, 32'(bus.err0), 32'(expErr));
        checkVal({t, "_rdata"}, bus.rdata0, expData);
        tick();
    endtask

    initial begin
        logic [3:0] rrExp [8];
        rrExp = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
        errCount = 0;
        checkCount = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 32'd0; bus.addr1 = 32'd0; bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
        bus.MemReadData = 32'hA5A5A5A5;
        rst = 1'b1;
        #12;
        // Reset state
        checkVal("rst_p0", p0Outs(), 32'd0);
        checkVal("rst_p1", p1Outs(), 32'd0);
        checkVal("rst_strobe", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
        checkVal("rst_addr", bus.MemAddr, 32'd0);
        checkVal("rst_wdata", bus.MemWriteData, 32'd0);
        tick();
        rst = 1'b0;

        // Port-0 write of 0xDEADBEEF to 0x10
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF;
        tick();
        checkVal("wr_gnt0", 32'(bus.gnt0), 32'd1);
        checkVal("wr_gnt1", 32'(bus.gnt1), 32'd0);
        checkVal("wr_strobe", {30'd0, bus.MemRead, bus.MemWrite}, 32'd1);
        checkVal("wr_addr", bus.MemAddr, 32'h10);
        checkVal("wr_wdata", bus.MemWriteData, 32'hDEADBEEF);
        bus.req0 = 1'b0;
        tick();
        checkVal("wr_done0", 32'(bus.done0), 32'd1);
        checkVal("wr_err0", 32'(bus.err0), 32'd0);
        checkVal("wr_strobe_off", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
        checkVal("wr_mem", memWord(16), 32'hDEADBEEF);
        tick();
        checkVal("wr_idle_p0", p0Outs(), 32'd0);
        checkVal("wr_hold_addr", bus.MemAddr, 32'h10);

        // Port-1 read back of 0x10
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h10;
        tick();
        checkVal("rd1_gnt1", 32'(bus.gnt1), 32'd1);
        checkVal("rd1_strobe", {30'd0, bus.MemRead, bus.MemWrite}, 32'd2);
        checkVal("rd1_p0_quiet", p0Outs(), 32'd0);
        bus.req1 = 1'b0;
        tick();
        checkVal("rd1_done1", 32'(bus.done1), 32'd1);
        checkVal("rd1_err1", 32'(bus.err1), 32'd0);
        checkVal("rd1_rdata1", bus.rdata1, 32'hDEADBEEF);
        checkVal("rd1_p0_quiet2", p0Outs(), 32'd0);
        tick();

        // Both ports requesting continuously from reset: alternate grants
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h24;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkVal($sformatf("rr_cyc%0d", i + 1),
                     {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'(rrExp[i]));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        checkVal("rr_idle", {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);

        // Boundary addresses: write top word via port 1, then port-0 reads
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h7C; bus.wdata1 = 32'h12345678;
        tick();
        checkVal("top_wr_strobe", {30'd0, bus.MemRead, bus.MemWrite}, 32'd1);
        bus.req1 = 1'b0;
        tick();
        checkVal("top_wr_err1", {30'd0, bus.done1, bus.err1}, 32'd2);
        tick();
        readP0(32'h7E, 1'b1, 32'd0);
        readP0(32'h80, 1'b1, 32'd0);
        readP0(32'h7D, 1'b1, 32'd0);
        readP0(32'h7C, 1'b0, 32'h12345678);

        // Asynchronous reset in the middle of a write access
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h40; bus.wdata0 = 32'hCAFEF00D;
        tick();
        checkVal("ar_strobe_pre", {30'd0, bus.MemRead, bus.MemWrite}, 32'd1);
        bus.req0 = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkVal("ar_strobe", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
        checkVal("ar_gnt0", 32'(bus.gnt0), 32'd0);
        checkVal("ar_addr", bus.MemAddr, 32'd0);
        checkVal("ar_wdata", bus.MemWriteData, 32'd0);
        tick();
        checkVal("ar_no_done", {30'd0, bus.done0, bus.done1}, 32'd0);
        checkVal("ar_mem", memWord(64), 32'd0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h20;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h24;
        rst = 1'b0;
        tick();
        checkVal("ar_tie", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 128, is the data-memory size in bytes and sets the legal address range.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1  access request from port 0 (MEM stage) / port 1 (loader/debug).
REQ-005 we0 / we1  input  1  1 = word write, 0 = word read, qualified by reqN.
REQ-006 addr0 / addr1  input  32  byte address of the word access.
REQ-007 wdata0 / wdata1  input  32  write data.
REQ-008 gnt0 / gnt1  output  1  one-cycle grant pulse; the request has been latched.
REQ-009 done0 / done1  output  1  one-cycle completion pulse for the granted access.
REQ-010 err0 / err1  output  1  completion with error, valid only with doneN.
REQ-011 rdata0 / rdata1  output  32  read data, valid only with doneN on a read.
REQ-012 MemAddr  output  32  address to data memory.
REQ-013 MemWriteData  output  32  write data to data memory.
REQ-014 MemWrite / MemRead  output  1  data-memory strobes; memory acts on negedge clk.
REQ-015 MemReadData  input  32  data-memory read result, stable by the posedge after the strobe cycle.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE; exactly one state active.
REQ-017 IDLE: on posedge with req0 or req1 high, arbitrate, latch the winner's we/addr/wdata, go to ACCESS; otherwise stay IDLE.
REQ-018 Arbitration: a single request wins; with both high, the port not granted last wins (round-robin); the last-grant register updates on every grant.
REQ-019 ACCESS lasts exactly one cycle: gntN high for the winner; MemRead = !we, MemWrite = we, both 0 if the access is illegal; next state DONE.
REQ-020 Illegal access: addr[1:0] != 0 or addr > MEM_BYTES-4; no memory strobe is issued.
REQ-021 DONE lasts exactly one cycle: doneN high for the winner; errN = illegal flag; rdataN = MemReadData captured at the ACCESS->DONE posedge for a legal read, otherwise 0.
REQ-022 DONE exit: with any request pending, arbitrate per REQ-018 and go directly to ACCESS (back-to-back); otherwise go to IDLE.
REQ-023 Requests are sampled only in IDLE and DONE; reqN during ACCESS is ignored. A requester holds reqN until gntN and drops it in the cycle after gntN unless it issues a new access.
REQ-024 Latency: request sampled at edge N -> gnt in cycle N+1 -> done in cycle N+2; sustained throughput is one access per 2 cycles.
REQ-025 MemRead and MemWrite are never both 1; both are 0 outside ACCESS.
REQ-026 MemAddr and MemWriteData hold the last latched values between accesses.
REQ-027 The loser's outputs gnt, done, err and rdata stay 0 throughout.

Reset
REQ-028 rst high forces IDLE immediately regardless of clk, including mid-ACCESS or mid-DONE; no strobe is issued after assertion.
REQ-029 Reset values: all gnt/done/err = 0, rdata0/1 = 0, MemRead = MemWrite = 0, MemAddr = MemWriteData = 0, last-grant = port 1, so port 0 wins the first tie.
REQ-030 A request pending at rst deassertion is sampled at the first posedge with rst low.

Verification
REQ-031 req0 write addr 0x10, data 0xDEADBEEF -> gnt0 in cycle N+1 with MemWrite=1 and MemAddr=0x10; done0 in N+2, err0=0; bytes 0x10..0x13 = DE AD BE EF.
REQ-032 req1 read addr 0x10 after REQ-031 -> MemRead=1 in ACCESS; done1 with rdata1=0xDEADBEEF, err1=0; port-0 outputs stay 0.
REQ-033 req0 and req1 both held high for 8 cycles from reset -> grants alternate 0,1,0,1 at 2-cycle spacing; no IDLE cycle between accesses.
REQ-034 Port-0 read at addr 0x7E (misaligned) and at 0x7D..0x80 range check with addr 0x80 -> no strobe, done0 with err0=1, rdata0=0; addr 0x7C read succeeds with err0=0.
REQ-035 rst asserted asynchronously mid-ACCESS of a write -> MemWrite drops immediately, all outputs reach reset values, no done pulse, and the next tie goes to port 0.
